// File: rtl/wired0_defines.sv
// wired0_defines: shared LSU types and constants (store-buffer entry, drain FSM states).
package wired0_defines;

   localparam int SB_LINE_OFS = 4;

   typedef struct packed {
      logic [31:0] paddr;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
      logic [3:0]  hit;
      logic        data_ok;
      logic        uncached;
   } sb_meta_t;

   typedef enum logic [2:0] {
      SBD_IDLE,
      SBD_WRITE,
      SBD_MISS_REQ,
      SBD_MISS_WAIT,
      SBD_UC_REQ,
      SBD_UC_WAIT,
      SBD_DISCARD
   } sb_drain_state_t;

endpackage

// File: rtl/wired_lsu_sb_credit.sv
// wired_lsu_sb_credit: count of committed stores still waiting in the store buffer.
module wired_lsu_sb_credit #(
   parameter int SB_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       flush,
   input  logic [1:0] commit_cnt,
   input  logic       pop,
   output logic [2:0] credit
);

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         credit <= '0;
      else
         credit <= flush ? 3'd0 : credit + {1'b0, commit_cnt} - {2'b0, pop};

   // a store cannot be committed in the same cycle the pipeline flushes it
   always_ff @(posedge clk)
      if (rst_n) begin
         assert (int'(credit) <= SB_DEPTH);
         assert (!(pop && credit == 3'd0));
         assert (!(flush && commit_cnt != 2'd0));
      end

endmodule

// File: rtl/wired_lsu_sb_drain.sv
// wired_lsu_sb_drain: retires committed store-buffer entries to dcache SRAM, refill or uncached bus.
// WIRED_LSU_SB_UNCACHED_EN enables the uncached store path.
module wired_lsu_sb_drain
   import wired0_defines::*;
#(
   parameter int SB_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        flush_i,
   input  logic [1:0]                  commit_cnt_i,
   input  logic [SB_DEPTH-1:0]         sb_valid_i,
   input  sb_meta_t                    sb_meta_i [SB_DEPTH],
   input  logic [$clog2(SB_DEPTH)-1:0] sb_top_i,
   output logic                        sb_pop_o,
   output logic                        dsram_wvalid_o,
   input  logic                        dsram_wready_i,
   output logic [31:0]                 dsram_waddr_o,
   output logic [3:0]                  dsram_wway_o,
   output logic [3:0]                  dsram_wstrb_o,
   output logic [31:0]                 dsram_wdata_o,
   output logic                        refill_req_o,
   input  logic                        refill_ack_i,
   input  logic                        refill_done_i,
   output logic [31:0]                 refill_addr_o,
   output logic                        uc_req_o,
   input  logic                        uc_ready_i,
   input  logic                        uc_done_i,
   output logic [31:0]                 uc_addr_o,
   output logic [3:0]                  uc_wstrb_o,
   output logic [31:0]                 uc_wdata_o,
   output logic                        drained_o
);

   sb_drain_state_t state, state_nxt;
   sb_meta_t        top;
   logic [2:0]      credit;
   logic            elig, uc, uc_rdy, uc_fin;

   assign top  = sb_meta_i[sb_top_i];
   assign elig = credit != 3'd0 && sb_valid_i[sb_top_i] && top.data_ok;

`ifdef WIRED_LSU_SB_UNCACHED_EN
   assign uc         = top.uncached;
   assign uc_rdy     = uc_ready_i;
   assign uc_fin     = uc_done_i;
   assign uc_req_o   = state == SBD_UC_REQ;
   assign uc_addr_o  = uc_req_o ? top.paddr : '0;
   assign uc_wstrb_o = uc_req_o ? top.wstrb : '0;
   assign uc_wdata_o = uc_req_o ? top.wdata : '0;
`else
   logic unused_uc;
   assign unused_uc  = ^{uc_ready_i, uc_done_i, top.uncached};
   assign uc         = 1'b0;
   assign uc_rdy     = 1'b0;
   assign uc_fin     = 1'b0;
   assign uc_req_o   = 1'b0;
   assign uc_addr_o  = '0;
   assign uc_wstrb_o = '0;
   assign uc_wdata_o = '0;
`endif

   wired_lsu_sb_credit #(.SB_DEPTH(SB_DEPTH)) u_credit (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush_i),
      .commit_cnt (commit_cnt_i),
      .pop        (sb_pop_o),
      .credit     (credit)
   );

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         state <= SBD_IDLE;
      else
         state <= state_nxt;

   // an accepted refill/uncached request cannot be cancelled, so a flush parks in DISCARD
   always_comb begin
      state_nxt = state;
      case (state)
         SBD_IDLE:      if (!flush_i && elig) state_nxt = uc ? SBD_UC_REQ : |top.hit ? SBD_WRITE : SBD_MISS_REQ;
         SBD_WRITE:     if (flush_i || dsram_wready_i) state_nxt = SBD_IDLE;
         SBD_MISS_REQ:  if (refill_ack_i) state_nxt = flush_i ? SBD_DISCARD : SBD_MISS_WAIT;
                        else if (flush_i) state_nxt = SBD_IDLE;
         SBD_MISS_WAIT: if (refill_done_i) state_nxt = SBD_IDLE;
                        else if (flush_i) state_nxt = SBD_DISCARD;
         SBD_UC_REQ:    if (uc_rdy) state_nxt = flush_i ? SBD_DISCARD : SBD_UC_WAIT;
                        else if (flush_i) state_nxt = SBD_IDLE;
         SBD_UC_WAIT:   if (uc_fin) state_nxt = SBD_IDLE;
                        else if (flush_i) state_nxt = SBD_DISCARD;
         SBD_DISCARD:   if (refill_done_i || uc_fin) state_nxt = SBD_IDLE;
         default:       state_nxt = SBD_IDLE;
      endcase
   end

   assign dsram_wvalid_o = state == SBD_WRITE && !flush_i;
   assign dsram_waddr_o  = dsram_wvalid_o ? top.paddr : '0;
   assign dsram_wway_o   = dsram_wvalid_o ? top.hit : '0;
   assign dsram_wstrb_o  = dsram_wvalid_o ? top.wstrb : '0;
   assign dsram_wdata_o  = dsram_wvalid_o ? top.wdata : '0;
   assign refill_req_o   = state == SBD_MISS_REQ;
   assign refill_addr_o  = refill_req_o ? {top.paddr[31:SB_LINE_OFS], {SB_LINE_OFS{1'b0}}} : '0;
   assign sb_pop_o       = !flush_i && credit != 3'd0 &&
                           ((dsram_wvalid_o && dsram_wready_i) || (state == SBD_UC_WAIT && uc_fin));
   assign drained_o      = credit == 3'd0 && state == SBD_IDLE;

endmodule
